// File: rtl/ov_deser_pkg.sv
// ov_deser_pkg: shared types for the OV7670 pixel deserializer.
// Holds pixel format enum, FSM state enum and per-format pixel masks.
package ov_deser_pkg;

   typedef enum logic [1:0] {
      MODE_RAW8   = 2'b00,
      MODE_RGB444 = 2'b01,
      MODE_RGB555 = 2'b10,
      MODE_RGB565 = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VBLANK,
      S_LINE_WAIT,
      S_BYTE_0,
      S_BYTE_1
   } state_t;

   localparam logic [15:0] MASK_RAW8   = 16'h00FF;
   localparam logic [15:0] MASK_RGB444 = 16'h0FFF;
   localparam logic [15:0] MASK_RGB555 = 16'h7FFF;
   localparam logic [15:0] MASK_RGB565 = 16'hFFFF;

   function automatic logic [15:0] mode_mask(input mode_t m);
      logic [15:0] r;
      unique case (m)
         MODE_RAW8:   r = MASK_RAW8;
         MODE_RGB444: r = MASK_RGB444;
         MODE_RGB555: r = MASK_RGB555;
         default:     r = MASK_RGB565;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ov_pixel_pack.sv
// ov_pixel_pack: combinational packer, {b0,b1} masked per pixel format.
// Ports: mode_q (format), b0 (first byte), b1 (second/only byte), pixel.
module ov_pixel_pack
   import ov_deser_pkg::*;
(
   input  mode_t       mode_q,
   input  logic [7:0]  b0,
   input  logic [7:0]  b1,
   output logic [15:0] pixel
);

   // RAW8 mask zeroes the b0 half, so the single byte rides in b1.
   assign pixel = {b0, b1} & mode_mask(mode_q);

endmodule

// File: rtl/ov_pixel_deser.sv
// ov_pixel_deser: OV7670 byte stream to pixel words with frame/line markers.
// Ports: PCLK, RST (sync, active-high), VSYNC, HREF, serial_byte, mode in;
// o_pixel, o_valid, o_sof, o_sol, o_x, o_y, o_err out.
// OV_PIXEL_DESER_CHECK_EN enables the sticky framing-error flag o_err.
module ov_pixel_deser
   import ov_deser_pkg::*;
#(
   parameter int MAX_COLS = 640,
   parameter int MAX_ROWS = 480,
   parameter int COL_W    = $clog2(MAX_COLS),
   parameter int ROW_W    = $clog2(MAX_ROWS)
) (
   input  logic             PCLK,
   input  logic             RST,
   input  logic             VSYNC,
   input  logic             HREF,
   input  logic [7:0]       serial_byte,
   input  logic [1:0]       mode,
   output logic [15:0]      o_pixel,
   output logic             o_valid,
   output logic             o_sof,
   output logic             o_sol,
   output logic [COL_W-1:0] o_x,
   output logic [ROW_W-1:0] o_y,
   output logic             o_err
);

   // Counters carry one extra bit so they can saturate at the limit.
   localparam logic [COL_W:0] COL_LIM = (COL_W+1)'(MAX_COLS);
   localparam logic [ROW_W:0] ROW_LIM = (ROW_W+1)'(MAX_ROWS);

   state_t         state;
   mode_t          mode_q;
   logic [7:0]     b0;
   logic [COL_W:0] col;
   logic [ROW_W:0] row;
   logic           sof_arm;

   logic [15:0]    pack_px;
   logic           in_line;
   logic           px_done;
   logic           col_ok;
   logic           row_ok;

   ov_pixel_pack u_pack (
      .mode_q (mode_q),
      .b0     (b0),
      .b1     (serial_byte),
      .pixel  (pack_px)
   );

   assign in_line = (state == S_LINE_WAIT) ||
                    (state == S_BYTE_0) ||
                    (state == S_BYTE_1);
   assign col_ok  = (col < COL_LIM);
   assign row_ok  = (row < ROW_LIM);

   // A pixel completes on this byte: single byte in RAW8, else 2nd byte.
   always_comb begin
      px_done = 1'b0;
      if (in_line && HREF && !VSYNC) begin
         if (state == S_BYTE_1)
            px_done = 1'b1;
         else
            px_done = (mode_q == MODE_RAW8);
      end
   end

   always_ff @(posedge PCLK) begin
      if (RST) begin
         state   <= S_IDLE;
         mode_q  <= MODE_RGB444;
         b0      <= '0;
         col     <= '0;
         row     <= '0;
         sof_arm <= 1'b0;
         o_pixel <= '0;
         o_valid <= 1'b0;
         o_sof   <= 1'b0;
         o_sol   <= 1'b0;
         o_x     <= '0;
         o_y     <= '0;
      end else begin
         o_valid <= 1'b0;
         o_sof   <= 1'b0;
         o_sol   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (VSYNC)
                  state <= S_VBLANK;
            end
            S_VBLANK: begin
               if (!VSYNC) begin
                  state   <= S_LINE_WAIT;
                  mode_q  <= mode_t'(mode);
                  row     <= '0;
                  col     <= '0;
                  sof_arm <= 1'b1;
               end
            end
            default: begin
               if (VSYNC) begin
                  state <= S_VBLANK;
                  col   <= '0;
               end else if (HREF) begin
                  if (px_done) begin
                     state <= S_BYTE_0;
                     if (col_ok)
                        col <= col + 1'b1;
                     if (col_ok && row_ok) begin
                        o_valid <= 1'b1;
                        o_pixel <= pack_px;
                        o_x     <= col[COL_W-1:0];
                        o_y     <= row[ROW_W-1:0];
                        o_sof   <= sof_arm;
                        o_sol   <= (col == '0);
                        sof_arm <= 1'b0;
                     end
                  end else begin
                     state <= S_BYTE_1;
                     b0    <= serial_byte;
                  end
               end else if (state != S_LINE_WAIT) begin
                  // End of line; a held b0 is simply abandoned.
                  state <= S_LINE_WAIT;
                  col   <= '0;
                  if (col != '0 && row_ok)
                     row <= row + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef OV_PIXEL_DESER_CHECK_EN
   logic err_evt;

   always_comb begin
      err_evt = 1'b0;
      if (in_line) begin
         if (VSYNC)
            err_evt = (row != ROW_LIM);
         else if (HREF)
            err_evt = px_done && !(col_ok && row_ok);
         else if (state != S_LINE_WAIT)
            err_evt = (state == S_BYTE_1) || (col != COL_LIM);
      end
   end

   always_ff @(posedge PCLK) begin
      if (RST)
         o_err <= 1'b0;
      else if (err_evt)
         o_err <= 1'b1;
   end
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov_pixel_deser.sv
// tb_ov_pixel_deser: directed vector bench for ov_pixel_deser.
// Runs with MAX_COLS=4, MAX_ROWS=4 so overflow and full frames stay short.
module tb_ov_pixel_deser;

`ifdef OV_PIXEL_DESER_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic        PCLK = 1'b0;
   logic        RST = 1'b1;
   logic        VSYNC = 1'b0;
   logic        HREF = 1'b0;
   logic [7:0]  serial_byte = 8'h00;
   logic [1:0]  mode = 2'b00;
   logic [15:0] o_pixel;
   logic        o_valid;
   logic        o_sof;
   logic        o_sol;
   logic [1:0]  o_x;
   logic [1:0]  o_y;
   logic        o_err;

   int checks = 0;
   int errors = 0;
   int nv;

   ov_pixel_deser #(
      .MAX_COLS (4),
      .MAX_ROWS (4)
   ) dut (
      .PCLK        (PCLK),
      .RST         (RST),
      .VSYNC       (VSYNC),
      .HREF        (HREF),
      .serial_byte (serial_byte),
      .mode        (mode),
      .o_pixel     (o_pixel),
      .o_valid     (o_valid),
      .o_sof       (o_sof),
      .o_sol       (o_sol),
      .o_x         (o_x),
      .o_y         (o_y),
      .o_err       (o_err)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        vs;
      logic        hr;
      logic [7:0]  b;
      logic [1:0]  m;
      logic        ev;
      logic [15:0] ep;
      logic [1:0]  ex;
      logic [1:0]  ey;
      logic        esof;
      logic        esol;
   } vec_t;

   vec_t vq[$];

   function automatic void add_in(input logic vs, input logic hr,
                                  input logic [7:0] b, input logic [1:0] m);
      vec_t v;
      v = '{vs, hr, b, m, 1'b0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0};
      vq.push_back(v);
   endfunction

   function automatic void add_px(input logic [7:0] b, input logic [1:0] m,
                                  input logic [15:0] ep, input int x,
                                  input int y, input logic sof,
                                  input logic sol);
      vec_t v;
      v = '{1'b0, 1'b1, b, m, 1'b1, ep, 2'(x), 2'(y), sof, sol};
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic vs, input logic hr,
                       input logic [7:0] b, input logic [1:0] m);
      @(negedge PCLK);
      VSYNC = vs;
      HREF = hr;
      serial_byte = b;
      mode = m;
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_pixel"}, o_pixel, 16'h0);
      chk({nm, "_valid"}, 16'(o_valid), 16'h0);
      chk({nm, "_sof"}, 16'(o_sof), 16'h0);
      chk({nm, "_sol"}, 16'(o_sol), 16'h0);
      chk({nm, "_x"}, 16'(o_x), 16'h0);
      chk({nm, "_y"}, 16'(o_y), 16'h0);
      chk({nm, "_err"}, 16'(o_err), 16'h0);
   endtask

   initial begin
      // RGB444 frame, 2 lines x 3 pixels
      add_in(1, 0, 8'h00, 1);
      add_in(1, 0, 8'h00, 1);
      add_in(0, 0, 8'h00, 1);
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < 3; x++) begin
            add_in(0, 1, 8'hF1, 1);
            add_px(8'h23, 1, 16'h0123, x, y, (x == 0 && y == 0), (x == 0));
         end
         add_in(0, 0, 8'h00, 1);
         add_in(0, 0, 8'h00, 1);
      end
      // RGB565 frame, mode switched to RGB555 mid-frame
      add_in(1, 0, 8'h00, 3);
      add_in(0, 0, 8'h00, 3);
      add_in(0, 1, 8'hAB, 3);
      add_px(8'hCD, 3, 16'hABCD, 0, 0, 1, 1);
      add_in(0, 1, 8'hAB, 2);
      add_px(8'hCD, 2, 16'hABCD, 1, 0, 0, 0);
      add_in(0, 0, 8'h00, 2);
      // next frame latches RGB555
      add_in(1, 0, 8'h00, 2);
      add_in(0, 0, 8'h00, 2);
      add_in(0, 1, 8'hAB, 2);
      add_px(8'hCD, 2, 16'h2BCD, 0, 0, 1, 1);
      add_in(0, 0, 8'h00, 2);
      // RAW8 back-to-back, then VSYNC+HREF together
      add_in(1, 0, 8'h00, 0);
      add_in(0, 0, 8'h00, 0);
      add_px(8'h10, 0, 16'h0010, 0, 0, 1, 1);
      add_px(8'h11, 0, 16'h0011, 1, 0, 0, 0);
      add_px(8'h12, 0, 16'h0012, 2, 0, 0, 0);
      add_in(1, 1, 8'h55, 0);
      add_in(0, 0, 8'h00, 0);
      // RAW8 line of 6 with MAX_COLS=4: last 2 dropped
      for (int x = 0; x < 4; x++)
         add_px(8'(8'h20 + x), 0, 16'(16'h20 + x), x, 0, (x == 0), (x == 0));
      add_in(0, 1, 8'h24, 0);
      add_in(0, 1, 8'h25, 0);
      add_in(0, 0, 8'h00, 0);

      // reset state
      RST = 1'b1;
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk_zero("reset");
      RST = 1'b0;

      foreach (vq[i]) begin
         step(vq[i].vs, vq[i].hr, vq[i].b, vq[i].m);
         chk($sformatf("v%0d_valid", i), 16'(o_valid), 16'(vq[i].ev));
         chk($sformatf("v%0d_sof", i), 16'(o_sof), 16'(vq[i].esof));
         chk($sformatf("v%0d_sol", i), 16'(o_sol), 16'(vq[i].esol));
         if (vq[i].ev) begin
            chk($sformatf("v%0d_pixel", i), o_pixel, vq[i].ep);
            chk($sformatf("v%0d_x", i), 16'(o_x), 16'(vq[i].ex));
            chk($sformatf("v%0d_y", i), 16'(o_y), 16'(vq[i].ey));
         end
      end

      // clean 4x4 RAW8 frame, then a partial RGB444 line
      RST = 1'b1;
      step(0, 0, 8'h00, 0);
      RST = 1'b0;
      step(1, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            step(0, 1, 8'(16 * y + x), 0);
            chk("clean_valid", 16'(o_valid), 16'h1);
            chk("clean_pixel", o_pixel, 16'(16 * y + x));
            chk("clean_xy", {8'(o_y), 8'(o_x)}, {8'(y), 8'(x)});
         end
         step(0, 0, 8'h00, 0);
      end
      step(1, 0, 8'h00, 1);
      chk("clean_err", 16'(o_err), 16'h0);
      step(0, 0, 8'h00, 1);
      nv = 0;
      step(0, 1, 8'hF1, 1);
      nv += int'(o_valid);
      step(0, 1, 8'h23, 1);
      nv += int'(o_valid);
      chk("part_pixel", o_pixel, 16'h0123);
      step(0, 1, 8'hF1, 1);
      nv += int'(o_valid);
      step(0, 0, 8'h00, 1);
      nv += int'(o_valid);
      chk("part_strobes", 16'(nv), 16'h1);
      chk("part_err", 16'(o_err), 16'(CHK));
      for (int i = 0; i < 3; i++)
         step(0, 0, 8'h00, 1);
      chk("part_err_sticky", 16'(o_err), 16'(CHK));
      RST = 1'b1;
      step(0, 0, 8'h00, 1);
      chk_zero("part_rst");
      RST = 1'b0;

      // column overflow flag timing
      step(1, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      for (int x = 0; x < 4; x++) begin
         step(0, 1, 8'h40, 0);
         chk("ovf_valid", 16'(o_valid), 16'h1);
      end
      chk("ovf_err_pre", 16'(o_err), 16'h0);
      step(0, 1, 8'h44, 0);
      chk("ovf_drop", 16'(o_valid), 16'h0);
      chk("ovf_err", 16'(o_err), 16'(CHK));

      // reset after first byte of a pixel
      RST = 1'b1;
      step(0, 0, 8'h00, 3);
      RST = 1'b0;
      step(1, 0, 8'h00, 3);
      step(0, 0, 8'h00, 3);
      step(0, 1, 8'hAB, 3);
      RST = 1'b1;
      step(0, 1, 8'hCD, 3);
      chk_zero("midpx_rst");
      RST = 1'b0;
      step(0, 1, 8'hAB, 3);
      step(0, 1, 8'hCD, 3);
      chk("idle_nostrobe", 16'(o_valid), 16'h0);
      step(1, 0, 8'h00, 3);
      step(0, 0, 8'h00, 3);
      step(0, 1, 8'hAB, 3);
      chk("resume_b0", 16'(o_valid), 16'h0);
      step(0, 1, 8'hCD, 3);
      chk("resume_valid", 16'(o_valid), 16'h1);
      chk("resume_pixel", o_pixel, 16'hABCD);
      chk("resume_sof", 16'(o_sof), 16'h1);
      step(0, 0, 8'h00, 3);
      chk("resume_pulse", 16'(o_valid), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
